fifo_wr_ctrl: RTL and testbench

Write-side pointer and flag controller of the async FIFO, paired with the read-side controller in the read clock domain.
- Owns the binary and Gray write pointers and gates memory write enables.
- Produces full, almost_full, fill level and a sticky overflow flag, all from the read pointer after it has been synchronized into the write domain.
- Sits between the write-domain producer, the dual-port FIFO memory and the write-to-read pointer synchronizer.

---
 rtl/fifo_wr_ctrl_pkg.sv | 33 +++
 rtl/fifo_gray2bin.sv | 13 +
 rtl/fifo_wr_ctrl.sv | 91 +++++++++
 tb/tb_fifo_wr_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and pointer geometry checks,
// used by both the write-side and read-side pointer controllers.
package fifo_wr_ctrl_pkg;

    localparam int PTR_MAX_W = 16;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

    // Narrower pointers are zero-extended, so the leading zeros leave the prefix XOR unchanged.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] i_gray);
        logic [PTR_MAX_W-1:0] v_bin;
        logic                 v_acc;
        v_bin = '0;
        v_acc = 1'b0;
        for (int i = PTR_MAX_W - 1; i >= 0; i--) begin
            v_acc    = v_acc ^ i_gray[i];
            v_bin[i] = v_acc;
        end
        return v_bin;
    endfunction

    function automatic bit depth_ok(input int depth, input int addr_width);
        return (addr_width >= 3) && (addr_width <= PTR_MAX_W) &&
               (depth == (1 << (addr_width - 1)));
    endfunction

    function automatic bit thresh_ok(input int thresh, input int depth);
        return (thresh >= 1) && (thresh <= depth);
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at and above it.
module fifo_gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[WIDTH-1:i];
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer and flag controller of the async FIFO. Flags and level are derived
// from the read pointer already synchronized into wclk, so occupancy is never under-reported.
module fifo_wr_ctrl
    import fifo_wr_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic                  ovf_clr,
    input  logic [ADDR_WIDTH-1:0] rptr_gray_sync,
    output logic                  wclken,
    output logic [ADDR_WIDTH-2:0] waddr,
    output logic [ADDR_WIDTH-1:0] wptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH-1:0] wlevel,
    output logic                  overflow
);

    localparam int MSB = ADDR_WIDTH - 1;

    if (!depth_ok(FIFO_DEPTH, ADDR_WIDTH)) begin : g_bad_depth
        $error("fifo_wr_ctrl: FIFO_DEPTH must equal 2**(ADDR_WIDTH-1) with ADDR_WIDTH >= 3");
    end
    if (!thresh_ok(AFULL_THRESH, FIFO_DEPTH)) begin : g_bad_thresh
        $error("fifo_wr_ctrl: AFULL_THRESH must lie in 1..FIFO_DEPTH");
    end

    logic [ADDR_WIDTH-1:0] r_wptr_bin;
    logic [ADDR_WIDTH-1:0] r_wptr_gray;
    logic                  r_overflow;

    logic [ADDR_WIDTH-1:0] w_rptr_bin_sync;
    logic [ADDR_WIDTH-1:0] w_full_cmp;
    logic [ADDR_WIDTH-1:0] w_wptr_next;
    logic [ADDR_WIDTH-1:0] w_level;
    logic                  w_full;
    logic                  w_wen;
    logic                  w_ovf_event;

    fifo_gray2bin #(
        .WIDTH (ADDR_WIDTH)
    ) u_rptr_g2b (
        .i_gray (rptr_gray_sync),
        .o_bin  (w_rptr_bin_sync)
    );

    // Full when the write pointer is exactly one lap ahead: in Gray code that means
    // the top two bits differ from the read pointer and the rest match.
    assign w_full_cmp = {~rptr_gray_sync[MSB:MSB-1], rptr_gray_sync[MSB-2:0]};
    assign w_full     = (r_wptr_gray == w_full_cmp);

    // Request/accept: winc is the producer's request; a word is accepted (memory written,
    // pointer advanced) on exactly the wclk edges where wclken is high. wrst_n gates it so
    // the memory is never written on a reset edge.
    assign w_wen       = winc & ~w_full & wrst_n;
    assign w_ovf_event = winc & w_full;
    assign w_wptr_next = r_wptr_bin + ADDR_WIDTH'(1);
    assign w_level     = r_wptr_bin - w_rptr_bin_sync;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_wptr_bin  <= '0;
            r_wptr_gray <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wen) begin
                r_wptr_bin  <= w_wptr_next;
                r_wptr_gray <= w_wptr_next ^ (w_wptr_next >> 1);
            end
            if (w_ovf_event) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign wclken      = w_wen;
    assign waddr       = r_wptr_bin[MSB-1:0];
    assign wptr_gray   = r_wptr_gray;
    assign full        = w_full;
    assign wlevel      = w_level;
    assign almost_full = (w_level >= ADDR_WIDTH'(AFULL_THRESH));
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed vector table, reset and wrap sequences, and a
// lagged-read-pointer stream checked against a reference pointer model.
module tb_fifo_wr_ctrl;

    localparam int AW = 4;

    logic          wclk;
    logic          wrst_n;
    logic          winc;
    logic          ovf_clr;
    logic [AW-1:0] rptr_gray_sync;
    logic          wclken;
    logic [AW-2:0] waddr;
    logic [AW-1:0] wptr_gray;
    logic          full;
    logic          almost_full;
    logic [AW-1:0] wlevel;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [AW-1:0] exp_q[$];

    typedef struct {
        logic          winc;
        logic          clr;
        logic [AW-1:0] rptr;
        logic          e_wclken;
        logic [AW-2:0] e_waddr;
        logic [AW-1:0] e_gray;
        logic          e_full;
        logic          e_afull;
        logic [AW-1:0] e_level;
        logic          e_ovf;
    } vec_t;

    vec_t vecs[$];

    fifo_wr_ctrl #(
        .FIFO_DEPTH   (8),
        .ADDR_WIDTH   (AW),
        .AFULL_THRESH (6)
    ) dut (
        .wclk           (wclk),
        .wrst_n         (wrst_n),
        .winc           (winc),
        .ovf_clr        (ovf_clr),
        .rptr_gray_sync (rptr_gray_sync),
        .wclken         (wclken),
        .waddr          (waddr),
        .wptr_gray      (wptr_gray),
        .full           (full),
        .almost_full    (almost_full),
        .wlevel         (wlevel),
        .overflow       (overflow)
    );

    // Clock and watchdog
    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [AW-1:0] g(input logic [AW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic vec_t mk(input logic w, input logic c, input logic [AW-1:0] r,
                                input logic en, input logic [AW-2:0] a, input logic [AW-1:0] gr,
                                input logic f, input logic af, input logic [AW-1:0] lv,
                                input logic ov);
        vec_t v;
        v.winc = w; v.clr = c; v.rptr = r;
        v.e_wclken = en; v.e_waddr = a; v.e_gray = gr;
        v.e_full = f; v.e_afull = af; v.e_level = lv; v.e_ovf = ov;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Driver tasks: inputs change just after the falling edge, outputs are sampled 1 ns later.
    task automatic drive(input logic w, input logic c, input logic [AW-1:0] r, input logic rst_n);
        winc           = w;
        ovf_clr        = c;
        rptr_gray_sync = r;
        wrst_n         = rst_n;
        #1;
    endtask

    task automatic tick();
        @(posedge wclk);
        @(negedge wclk);
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, "_wclken"}, int'(wclken), int'(v.e_wclken));
        check({tag, "_waddr"}, int'(waddr), int'(v.e_waddr));
        check({tag, "_gray"}, int'(wptr_gray), int'(v.e_gray));
        check({tag, "_full"}, int'(full), int'(v.e_full));
        check({tag, "_afull"}, int'(almost_full), int'(v.e_afull));
        check({tag, "_level"}, int'(wlevel), int'(v.e_level));
        check({tag, "_ovf"}, int'(overflow), int'(v.e_ovf));
    endtask

    initial begin
        logic [AW-1:0] wbin, r_true, rp0, rp1, rsync, wd0, wd1, lvl;
        logic          e_full, e_ovf;
        int            accepted, cyc;

        // Vector table: expected outputs seen before the edge that applies the inputs.
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(1, 0, 4'b0000, 1, 3'(i), g(4'(i)), 0, (i >= 6), 4'(i), 0));
        end
        vecs.push_back(mk(1, 0, 4'b0000, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1));
        vecs.push_back(mk(0, 1, 4'b0000, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 0));
        vecs.push_back(mk(0, 0, 4'b0001, 0, 3'd0, 4'b1100, 0, 1, 4'd7, 0));
        vecs.push_back(mk(1, 0, 4'b0001, 1, 3'd0, 4'b1100, 0, 1, 4'd7, 0));
        vecs.push_back(mk(0, 0, 4'b0001, 0, 3'd1, 4'b1101, 1, 1, 4'd8, 0));
        vecs.push_back(mk(1, 0, 4'b0001, 0, 3'd1, 4'b1101, 1, 1, 4'd8, 0));
        vecs.push_back(mk(1, 1, 4'b0001, 0, 3'd1, 4'b1101, 1, 1, 4'd8, 1));
        vecs.push_back(mk(0, 0, 4'b0001, 0, 3'd1, 4'b1101, 1, 1, 4'd8, 1));
        vecs.push_back(mk(0, 1, 4'b0001, 0, 3'd1, 4'b1101, 1, 1, 4'd8, 1));
        vecs.push_back(mk(0, 0, 4'b0001, 0, 3'd1, 4'b1101, 1, 1, 4'd8, 0));
        vecs.push_back(mk(1, 0, 4'b0011, 1, 3'd1, 4'b1101, 0, 1, 4'd7, 0));
        vecs.push_back(mk(0, 0, 4'b0011, 0, 3'd2, 4'b1111, 1, 1, 4'd8, 0));

        // Reset state
        drive(0, 0, 4'b0000, 0);
        tick();
        tick();
        drive(0, 0, 4'b0000, 1);
        check_vec("reset", mk(0, 0, 4'b0000, 0, 3'd0, 4'b0000, 0, 0, 4'd0, 0));

        foreach (vecs[k]) begin
            drive(vecs[k].winc, vecs[k].clr, vecs[k].rptr, 1);
            check_vec($sformatf("v%0d", k), vecs[k]);
            tick();
        end

        // Reset while full, overflowed and still requesting writes
        drive(0, 0, 4'b0000, 0);
        tick();
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 4'b0000, 1);
            tick();
        end
        drive(1, 0, 4'b0000, 1);
        check("rst_pre_full", int'(full), 1);
        check("rst_pre_ovf", int'(overflow), 1);
        drive(1, 0, 4'b0000, 0);
        check("rst_edge_wclken", int'(wclken), 0);
        tick();
        drive(0, 0, 4'b0000, 1);
        check_vec("rst_after", mk(0, 0, 4'b0000, 0, 3'd0, 4'b0000, 0, 0, 4'd0, 0));

        // Streaming writes against a read pointer that lags by two synchronizer cycles
        wbin = '0; r_true = '0; rp0 = '0; rp1 = '0; wd0 = '0; wd1 = '0;
        e_ovf = 1'b0;
        accepted = 0;
        cyc = 0;
        while (accepted < 20 && cyc < 200) begin
            rsync  = rp1;
            lvl    = wbin - rsync;
            e_full = (lvl == 4'd8);
            drive(1, 0, g(rsync), 1);
            check("t4_level", int'(wlevel), int'(lvl));
            check("t4_level_range", int'(wlevel <= 4'd8), 1);
            check("t4_full", int'(full), int'(e_full));
            check("t4_gray", int'(wptr_gray), int'(g(wbin)));
            check("t4_wclken", int'(wclken), int'(!e_full));
            check("t4_ovf", int'(overflow), int'(e_ovf));
            if (!e_full) exp_q.push_back(wbin & 4'd7);
            if (wclken) begin
                if (exp_q.size() == 0) begin
                    check("t4_unexpected_write", 1, 0);
                end else begin
                    check("t4_waddr", int'(waddr), int'(exp_q.pop_front()));
                end
            end
            tick();
            if (!e_full) begin
                wbin = wbin + 4'd1;
                accepted++;
            end else begin
                e_ovf = 1'b1;
            end
            if ((cyc % 2) == 1 && r_true != wd1) r_true = r_true + 4'd1;
            rp1 = rp0;
            rp0 = r_true;
            wd1 = wd0;
            wd0 = wbin;
            cyc++;
        end
        check("t4_accepted", accepted, 20);
        check("t4_queue_empty", exp_q.size(), 0);
        drive(0, 0, g(rp1), 1);
        check("t4_wrapped_gray", int'(wptr_gray), int'(g(4'd4)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
